// File: rtl/load_store_unit_if.sv
// Core-side operation bundle plus data-memory bus of the load/store unit.
interface load_store_unit_if;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [6:0]  opcode;
  logic [2:0]  fun3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        lsu_done;
  logic        misaligned;
  logic        bus_err;
  logic [31:0] exc_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  lsu_valid, opcode, fun3, addr, wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output lsu_ready, rdata, lsu_done, misaligned,
    output bus_err, exc_addr,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output lsu_valid, opcode, fun3, addr, wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  lsu_ready, rdata, lsu_done, misaligned,
    input  bus_err, exc_addr,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: decode, alignment trap, bus request,
// load extraction and grant/response timeout.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    fun3_q, fun3_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wd_q, wd_d;
  logic          req_q, req_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          done_q, done_d;
  logic          mis_q, mis_d;
  logic          err_q, err_d;
  logic [31:0]   exc_q, exc_d;

  logic          is_ld, is_st, legal, unal, lim;
  logic [1:0]    size;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   ld_val;

  always_comb begin
    is_ld = bus.opcode == OP_LOAD;
    is_st = bus.opcode == OP_STORE;
    case (bus.fun3)
      3'b000, 3'b001, 3'b010: legal = is_ld | is_st;
      3'b100, 3'b101:         legal = is_ld;
      default:                legal = 1'b0;
    endcase
    size = bus.fun3[1:0];
    unal = (size == 2'b10 && bus.addr[1:0] != 2'b00) ||
           (size == 2'b01 && bus.addr[0]);
    unique case (1'b1)
      size == 2'b10: begin
        be_n = 4'b1111;
        wd_n = bus.wdata;
      end
      size == 2'b01: begin
        be_n = 4'b0011 << bus.addr[1:0];
        wd_n = {2{bus.wdata[15:0]}};
      end
      default: begin
        be_n = 4'b0001 << bus.addr[1:0];
        wd_n = {4{bus.wdata[7:0]}};
      end
    endcase
  end

  // Lane selection and sign/zero extension of the returned word
  always_comb begin
    unique case (addr_q[1:0])
      2'd0:    byte_s = bus.mem_rdata[7:0];
      2'd1:    byte_s = bus.mem_rdata[15:8];
      2'd2:    byte_s = bus.mem_rdata[23:16];
      default: byte_s = bus.mem_rdata[31:24];
    endcase
    half_s = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    unique case (fun3_q[1:0])
      2'b00:   ld_val = {{24{~fun3_q[2] & byte_s[7]}}, byte_s};
      2'b01:   ld_val = {{16{~fun3_q[2] & half_s[15]}}, half_s};
      default: ld_val = bus.mem_rdata;
    endcase
  end

  assign lim = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    fun3_d  = fun3_q;
    we_d    = we_q;
    be_d    = be_q;
    wd_d    = wd_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.lsu_valid && legal) begin
          if (unal) begin
            mis_d = 1'b1;
            exc_d = bus.addr;
          end else begin
            state_d = S_REQ;
            cnt_d   = '0;
            req_d   = 1'b1;
            addr_d  = bus.addr;
            fun3_d  = bus.fun3;
            we_d    = is_st;
            be_d    = be_n;
            wd_d    = wd_n;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          req_d = 1'b0;
          cnt_d = '0;
          if (we_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (lim) begin
          err_d   = 1'b1;
          exc_d   = addr_q;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          rdata_d = ld_val;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (lim) begin
          err_d   = 1'b1;
          exc_d   = addr_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      fun3_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
      req_q   <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      fun3_q  <= fun3_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.lsu_ready  = state_q == S_IDLE;
  assign bus.rdata      = rdata_q;
  assign bus.lsu_done   = done_q;
  assign bus.misaligned = mis_q;
  assign bus.bus_err    = err_q;
  assign bus.exc_addr   = exc_q;
  assign bus.mem_req    = req_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.mem_be     = be_q;
  assign bus.mem_wdata  = wd_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Core-side initiator for the data memory bus of the RV32I core. It accepts one load/store per handshake, decoded from opcode/fun3, and checks alignment. It issues a word-aligned request with byte enables and lane-replicated store data, waits for grant and response, then returns sign- or zero-extended load data. It stalls the core via lsu_ready and traps misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 16, max cycles spent in REQ or WAIT before bus_err; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
lsu_valid  in  1  core presents an operation
lsu_ready  out  1  high when state==IDLE (combinational from state)
opcode  in  7  0000011 load, 0100011 store; any other value is ignored
fun3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  byte address
wdata  in  32  store data, low bits significant
rdata  out  32  extended load result, held until next load completes
lsu_done  out  1  one-cycle pulse when an operation completes
misaligned  out  1  one-cycle pulse when an operation is rejected for alignment
bus_err  out  1  one-cycle pulse on timeout
exc_addr  out  32  addr of the last misaligned or timed-out operation
mem_req  out  1  request valid, held until mem_gnt
mem_we  out  1  1 store, 0 load
mem_addr  out  32  {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-aligned store data
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  load data valid
mem_rdata  in  32  load data word

Behaviour:
- Reset (async, immediate): state=IDLE. All registered outputs are 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, rdata, lsu_done, misaligned, bus_err, exc_addr. The timeout counter is 0. lsu_ready=1 after reset.
- Reset during REQ or WAIT abandons the operation: mem_req drops asynchronously, no done or bus_err pulse is produced, and a late mem_rvalid after reset is ignored in IDLE.
- Accept: a rising edge with lsu_valid && lsu_ready and a legal {opcode,fun3} (loads 000/001/010/100/101; stores 000/001/010). Any other combination is ignored and no pulse is produced.
- Alignment: W requires addr[1:0]==0. H/HU requires addr[0]==0. B/BU is always aligned.
- Misaligned accept: pulse misaligned in the next cycle, set exc_addr=addr, and stay in IDLE. No memory request is issued.
- Aligned accept: register the request and go to REQ. mem_req goes high in the next cycle.
- Byte enables: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111. Loads drive mem_be the same way.
- Store data: SB -> {4{wdata[7:0]}}; SH -> {2{wdata[15:0]}}; SW -> wdata.
- REQ: mem_req, mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_gnt is sampled high.
  - On grant: mem_req drops next cycle.
  - Store: lsu_done pulses next cycle, then IDLE.
  - Load: go to WAIT.
  - mem_rvalid is ignored in REQ.
- WAIT: when mem_rvalid is sampled high, rdata=extract(mem_rdata) and lsu_done pulses next cycle, then IDLE.
  - Extraction selects byte lane addr[1:0] or half lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Timeout: the counter clears on entry to REQ and on entry to WAIT, and increments each cycle without the awaited event.
  - When the counter reaches TIMEOUT-1 with no event: pulse bus_err, set exc_addr, drop mem_req, go to IDLE, leave rdata unchanged.
  - If the event arrives in the same cycle as the limit, the event wins.
- Latency with gnt/rvalid as early as possible: store done at accept+2 cycles; load done at accept+3 cycles.
- lsu_done, misaligned and bus_err are mutually exclusive.

Test Plan:
- SW addr=0x0000_0104, wdata=0xDEADBEEF, mem_gnt tied 1 -> mem_addr=0x104, mem_be=1111, mem_wdata=0xDEADBEEF, mem_we=1; lsu_done exactly 2 cycles after accept.
- SB addr=0x0000_0007, wdata=0x0000_00A5 -> mem_addr=0x4, mem_be=1000, mem_wdata=0xA5A5A5A5; SH addr=0x6, wdata=0x1234 -> mem_be=1100, mem_wdata=0x12341234.
- Loads with mem_rdata=0x80FF7F01: LB addr=0x2 -> 0xFFFFFFFF; LBU addr=0x3 -> 0x00000080; LH addr=0x2 -> 0xFFFF80FF; LHU addr=0x0 -> 0x00007F01; LW -> 0x80FF7F01. Each result appears with lsu_done, and rdata holds afterwards.
- LW addr=0x0000_0102 -> misaligned pulse, exc_addr=0x102, mem_req never asserts, lsu_ready stays 1; LH addr=0x1 -> misaligned.
- mem_gnt delayed 5 cycles -> mem_req and mem_addr stable for all 5 cycles. With TIMEOUT=16 and gnt never asserted -> bus_err pulses, mem_req drops, next op accepted normally.
- Assert reset while in WAIT -> mem_req=0 and all outputs 0 immediately. A mem_rvalid after reset release produces no lsu_done.
